prog_counter_ras: RTL and testbench

//  Parametrised program counter for the Troy WideWord fetch stage; successor to the fixed 32-bit PC.

---
 rtl/prog_counter_ras.sv | 186 ++++++++++++++++++
 tb/tb_prog_counter_ras.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/prog_counter_ras.sv
// prog_counter_ras: fetch-stage program counter with stall hold, branch/jump
// redirect and call/return through an internal circular return-address stack.
// Optional feature macro: PC_RAS_EN. When it is defined, the return-address
// stack is built. When it is undefined, call acts as a plain jump, ret is
// ignored, and the stack flags are tied to their empty values.
// Vectors are [0:PC_W-1], so bit 0 is the MSB.
module prog_counter_ras #(
  parameter int              PC_W      = 32,
  parameter int              INC       = 4,
  parameter logic [0:PC_W-1] RESET_VEC = {PC_W{1'b0}},
  parameter int              RAS_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [0:PC_W-1] br_target,
  input  logic            call,
  input  logic            ret,
  output logic [0:PC_W-1] pc,
  output logic [0:PC_W-1] pc_plus,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_err
);

  localparam int              INC_LOG2   = $clog2(INC);
  localparam logic [0:PC_W-1] ONE_V      = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [0:PC_W-1] INC_V      = ONE_V << INC_LOG2;
  localparam logic [0:PC_W-1] ALIGN_MASK = ~(INC_V - ONE_V);

  // Clear the low log2(INC) bits of any address loaded into the PC.
  function automatic logic [0:PC_W-1] align_addr(input logic [0:PC_W-1] addr);
    return addr & ALIGN_MASK;
  endfunction

  logic [0:PC_W-1] pc_r;
  logic [0:PC_W-1] pc_plus_s;
  logic [0:PC_W-1] pc_next_s;

  assign pc_plus_s = pc_r + INC_V;
  assign pc        = pc_r;
  assign pc_plus   = pc_plus_s;

`ifdef PC_RAS_EN

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(RAS_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [0:PC_W-1]  ras_mem_r [RAS_DEPTH];
  logic [PTR_W-1:0] top_r;
  logic [PTR_W-1:0] top_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic             empty_r;
  logic             full_r;
  logic             err_r;
  logic             pop_s;
  logic             underflow_s;
  logic             push_s;
  logic             overflow_s;

  // Decode this cycle's stack operation; ret outranks call, stall drops both.
  always_comb begin
    pop_s       = 1'b0;
    underflow_s = 1'b0;
    push_s      = 1'b0;
    overflow_s  = 1'b0;
    if (stall) begin
      pop_s = 1'b0;
    end else if (ret) begin
      if (cnt_r == CNT_ZERO) begin
        underflow_s = 1'b1;
      end else begin
        pop_s = 1'b1;
      end
    end else if (call) begin
      push_s     = 1'b1;
      overflow_s = (cnt_r == CNT_MAX);
    end else begin
      push_s = 1'b0;
    end
  end

  // Next stack pointer and occupancy; a full push wraps over the oldest entry.
  always_comb begin
    top_next_s = top_r;
    cnt_next_s = cnt_r;
    if (pop_s) begin
      top_next_s = top_r - PTR_ONE;
      cnt_next_s = cnt_r - CNT_ONE;
    end else if (push_s) begin
      top_next_s = top_r + PTR_ONE;
      if (overflow_s) begin
        cnt_next_s = cnt_r;
      end else begin
        cnt_next_s = cnt_r + CNT_ONE;
      end
    end else begin
      top_next_s = top_r;
    end
  end

  // Next PC; the stack is only read on a pop, so an empty stack never feeds the PC.
  always_comb begin
    pc_next_s = pc_plus_s;
    if (stall) begin
      pc_next_s = pc_r;
    end else if (pop_s) begin
      pc_next_s = align_addr(ras_mem_r[top_r]);
    end else if (underflow_s) begin
      pc_next_s = pc_plus_s;
    end else if (call || br_taken) begin
      pc_next_s = align_addr(br_target);
    end else begin
      pc_next_s = pc_plus_s;
    end
  end

  // Stack storage: write the link value into the slot the pointer moves to.
  always_ff @(posedge clk) begin
    if (rst && push_s) begin
      ras_mem_r[top_next_s] <= pc_plus_s;
    end
  end

  // PC, stack pointer, occupancy and registered status flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_r    <= RESET_VEC;
      top_r   <= {PTR_W{1'b0}};
      cnt_r   <= CNT_ZERO;
      empty_r <= 1'b1;
      full_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      pc_r    <= pc_next_s;
      top_r   <= top_next_s;
      cnt_r   <= cnt_next_s;
      empty_r <= (cnt_next_s == CNT_ZERO);
      full_r  <= (cnt_next_s == CNT_MAX);
      err_r   <= err_r | underflow_s | overflow_s;
    end
  end

  assign ras_empty = empty_r;
  assign ras_full  = full_r;
  assign ras_err   = err_r;

`else

  logic unused_ret_s;
  assign unused_ret_s = ret;

  // Next PC without a stack: call is a plain jump and ret falls through.
  always_comb begin
    pc_next_s = pc_plus_s;
    if (stall) begin
      pc_next_s = pc_r;
    end else if (call || br_taken) begin
      pc_next_s = align_addr(br_target);
    end else begin
      pc_next_s = pc_plus_s;
    end
  end

  // PC register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_r <= RESET_VEC;
    end else begin
      pc_r <= pc_next_s;
    end
  end

  assign ras_empty = 1'b1;
  assign ras_full  = 1'b0;
  assign ras_err   = 1'b0;

`endif

endmodule

// File: tb/tb_prog_counter_ras.sv
// Self-checking bench for prog_counter_ras (PC_W=32, INC=4, RESET_VEC=0,
// RAS_DEPTH=8). Adapts its expectations to whether PC_RAS_EN is defined.
module tb_prog_counter_ras;

`ifdef PC_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        call = 1'b0;
  logic        ret = 1'b0;
  logic [31:0] pc;
  logic [31:0] pc_plus;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_err;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: PC value, stack as a queue (back = newest), sticky error.
  logic [31:0] m_pc;
  logic [31:0] m_q[$];
  logic        m_err;

  prog_counter_ras #(
    .PC_W(32), .INC(4), .RESET_VEC(32'h0), .RAS_DEPTH(8)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken),
    .br_target(br_target), .call(call), .ret(ret), .pc(pc),
    .pc_plus(pc_plus), .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_err(ras_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        br;
    logic        c;
    logic        r;
    logic [31:0] tgt;
    logic [31:0] e_pc;
    logic        e_empty;
    logic        e_full;
    logic        e_err;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic void m_reset();
    m_pc  = 32'h0;
    m_q.delete();
    m_err = 1'b0;
  endfunction

  function automatic void m_step(input logic st, input logic br, input logic [31:0] tgt,
                                 input logic c, input logic r);
    logic [31:0] v;
    if (st) return;
    if (RAS_ON && r) begin
      if (m_q.size() == 0) begin
        m_pc  = m_pc + 32'd4;
        m_err = 1'b1;
      end else begin
        v    = m_q.pop_back();
        m_pc = v & ~32'h3;
      end
    end else if (c || br) begin
      if (RAS_ON && c) begin
        if (m_q.size() == 8) begin
          void'(m_q.pop_front());
          m_err = 1'b1;
        end
        m_q.push_back(m_pc + 32'd4);
      end
      m_pc = tgt & ~32'h3;
    end else begin
      m_pc = m_pc + 32'd4;
    end
  endfunction

  task automatic check_model(input string tag);
    check({tag, ".pc"}, pc, m_pc);
    check({tag, ".pc_plus"}, pc_plus, m_pc + 32'd4);
    check({tag, ".empty"}, {31'd0, ras_empty}, {31'd0, m_q.size() == 0});
    check({tag, ".full"}, {31'd0, ras_full}, {31'd0, m_q.size() == 8});
    check({tag, ".err"}, {31'd0, ras_err}, {31'd0, m_err});
  endtask

  task automatic apply(input logic st, input logic br, input logic [31:0] tgt,
                       input logic c, input logic r);
    @(negedge clk);
    rst = 1'b1; stall = st; br_taken = br; br_target = tgt; call = c; ret = r;
    @(posedge clk);
    #1;
    m_step(st, br, tgt, c, r);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    m_reset();
    check("reset.pc", pc, 32'h0);
    check("reset.flags", {29'd0, ras_empty, ras_full, ras_err}, {29'd0, 1'b1, 1'b0, 1'b0});
  endtask

  initial begin
    // Reset, then sequential advance.
    do_reset(2);
    for (int i = 0; i < 16; i++) begin
      apply(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      check("seq.pc", pc, 32'd4 * (i + 1));
      check("seq.empty", {31'd0, ras_empty}, 32'd1);
    end

    // Table of single-edge vectors starting from pc=0.
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h004, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h008, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h400, 32'h400, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h900, 32'h400, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h400, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h404, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h403, 32'h400, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h800, 32'h800, !RAS_ON, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h804, !RAS_ON, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,   RAS_ON ? 32'h404 : 32'h808, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,   RAS_ON ? 32'h408 : 32'h80C, 1'b1, 1'b0, RAS_ON};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h100, RAS_ON ? 32'h40C : 32'h100, 1'b1, 1'b0, RAS_ON};
    do_reset(1);
    for (int i = 0; i < 12; i++) begin
      apply(tbl[i].st, tbl[i].br, tbl[i].tgt, tbl[i].c, tbl[i].r);
      check($sformatf("tbl%0d.pc", i), pc, tbl[i].e_pc);
      check($sformatf("tbl%0d.pc_plus", i), pc_plus, tbl[i].e_pc + 32'd4);
      check($sformatf("tbl%0d.flags", i), {29'd0, ras_empty, ras_full, ras_err},
            {29'd0, tbl[i].e_empty, tbl[i].e_full, tbl[i].e_err});
    end

    // Wrap-around at the top of the address space.
    apply(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    check("wrap.pre", pc, 32'hFFFF_FFFC);
    check("wrap.pc_plus", pc_plus, 32'h0);
    apply(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("wrap.pc", pc, 32'h0);

    // Nine nested calls, then nine returns.
    do_reset(1);
    for (int i = 0; i < 9; i++) begin
      apply(1'b0, 1'b0, 32'h1000 * (i + 1), 1'b1, 1'b0);
      check_model($sformatf("nest.call%0d", i));
      if (i == 7) check("nest.full8", {31'd0, ras_full}, {31'd0, RAS_ON});
      if (i == 8) check("nest.err9", {31'd0, ras_err}, {31'd0, RAS_ON});
    end
    for (int i = 0; i < 9; i++) begin
      apply(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      check_model($sformatf("nest.ret%0d", i));
    end

    // Reset in the middle of a call chain, with a call pending.
    do_reset(1);
    for (int i = 0; i < 3; i++) apply(1'b0, 1'b0, 32'h2000 + 32'h10 * i, 1'b1, 1'b0);
    check_model("chain");
    @(negedge clk);
    call = 1'b1; br_target = 32'h3000;
    do_reset(1);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset(1);
      end else begin
        apply($urandom_range(0, 99) < 12, $urandom_range(0, 99) < 15, $urandom(),
              $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 28);
        check_model("rand");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
